// File: rtl/jtframe_sdram_pkg.sv
// Shared SDRAM definitions: command encodings {CS,RAS,CAS,WE}, bank FSM state codes and address split helper.
// Combinational constants only; no latency, no flow control.
package jtframe_sdram_pkg;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRE      = 3'd1;
    localparam logic [2:0] ST_WAIT_RP  = 3'd2;
    localparam logic [2:0] ST_ACT      = 3'd3;
    localparam logic [2:0] ST_WAIT_RCD = 3'd4;
    localparam logic [2:0] ST_RW       = 3'd5;
    localparam logic [2:0] ST_DATA     = 3'd6;
    localparam logic [2:0] ST_WAIT_WR  = 3'd7;

    // 22-bit address maps to 13-bit row + 9-bit column; wider parts use 10 column bits
    function automatic int col_w(input int aw);
        return (aw == 22) ? 9 : 10;
    endfunction

endpackage

// File: rtl/jtframe_sdram_bank_ctl_if.sv
// Requester, arbiter and SDRAM pin bundle for one bank controller.
// Level rd/wr held until rdy; bg grants br in the same cycle.
interface jtframe_sdram_bank_ctl_if #(parameter int AW = 22);
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic          ack;
    logic          dst;
    logic          dok;
    logic          rdy;
    logic          br;
    logic          bg;
    logic          dq_busy;
    logic          all_dq_busy;
    logic          set_prech;
    logic          row_open;
    logic [12:0]   row;
    logic [3:0]    cmd;
    logic [12:0]   sdram_a;

    modport master (
        output addr, rd, wr, bg, all_dq_busy, set_prech,
        input  ack, dst, dok, rdy, br, dq_busy, row_open, row, cmd, sdram_a
    );

    modport slave (
        input  addr, rd, wr, bg, all_dq_busy, set_prech,
        output ack, dst, dok, rdy, br, dq_busy, row_open, row, cmd, sdram_a
    );
endinterface

// File: rtl/jtframe_sdram_bank_timer.sv
// Loadable 4-bit down-counter with zero flag; load takes effect next cycle, then counts to 0 and holds.
// No backpressure: load always wins over counting.
module jtframe_sdram_bank_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] cnt,
    output logic       zero
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             cnt <= 4'd0;
        else if (load)       cnt <= load_val;
        else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    assign zero = (cnt == 4'd0);
endmodule

// File: rtl/jtframe_sdram_bank_ctl.sv
// Per-bank SDRAM sequencer; read rdy 1+CL+BURST-1 cycles after request on a row hit, stalls while bg low or DQ busy.
// Define JTFRAME_SDRAM_ROWCLOSE_EN to precharge a row left idle for CLOSE_CNT cycles.
module jtframe_sdram_bank_ctl
    import jtframe_sdram_pkg::*;
#(
    parameter int AW        = 22,
    parameter int CL        = 2,
    parameter int BURST     = 4,
    parameter int TRP       = 2,
    parameter int TRCD      = 2,
    parameter int TWR       = 2,
    parameter int CLOSE_CNT = 64
) (
    input  logic clk,
    input  logic rst,
    jtframe_sdram_bank_ctl_if.slave bus
);
    localparam int COLW = col_w(AW);

    if (CL >= 16 || BURST >= 16 || TRP >= 16 || TRCD >= 16 || TWR >= 16 || CLOSE_CNT < 2) begin : g_cfg_err
        $error("jtframe_sdram_bank_ctl: timing parameter out of range");
    end

    logic [2:0]  st, nxt, after_rp;
    logic [12:0] row, addr_row;
    logic [9:0]  col;
    logic        row_open, is_wr, req, hit, issue_rw, in_data, close_now;
    logic        ld, zero;
    logic [3:0]  ld_val, cnt;

    assign addr_row = 13'(bus.addr >> COLW);
    assign col      = 10'(bus.addr[COLW-1:0]);
    assign req      = bus.rd | bus.wr;
    assign hit      = row_open && (row == addr_row);
    assign issue_rw = (st == ST_RW) && bus.bg && !bus.all_dq_busy;
    assign in_data  = (st == ST_DATA);
    // an auto-close precharge with no pending request falls back to IDLE
    assign after_rp = req ? ST_ACT : ST_IDLE;

`ifdef JTFRAME_SDRAM_ROWCLOSE_EN
    localparam int CLW = $clog2(CLOSE_CNT);
    logic [CLW-1:0] idle_cnt;

    assign close_now = (st == ST_IDLE) && row_open && !req && (idle_cnt == CLW'(CLOSE_CNT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if (st != ST_IDLE || req || bus.set_prech || !row_open || close_now)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign close_now = 1'b0;
`endif

    always_comb begin
        nxt    = st;
        ld     = 1'b0;
        ld_val = 4'd0;
        case (st)
            ST_IDLE: begin
                if (req)            nxt = hit ? ST_RW : (row_open ? ST_PRE : ST_ACT);
                else if (close_now) nxt = ST_PRE;
            end
            ST_PRE: if (bus.bg) begin
                if (TRP > 1) begin nxt = ST_WAIT_RP; ld = 1'b1; ld_val = 4'(TRP - 2); end
                else nxt = after_rp;
            end
            ST_WAIT_RP: if (zero) nxt = after_rp;
            ST_ACT: if (bus.bg) begin
                if (TRCD > 1) begin nxt = ST_WAIT_RCD; ld = 1'b1; ld_val = 4'(TRCD - 2); end
                else nxt = ST_RW;
            end
            ST_WAIT_RCD: if (zero) nxt = ST_RW;
            ST_RW: if (issue_rw) begin
                if (!bus.wr)       begin nxt = ST_DATA;    ld = 1'b1; ld_val = 4'(CL + BURST - 2); end
                else if (BURST > 1) begin nxt = ST_DATA;    ld = 1'b1; ld_val = 4'(BURST - 2); end
                else if (TWR > 0)   begin nxt = ST_WAIT_WR; ld = 1'b1; ld_val = 4'(TWR - 1); end
                else nxt = ST_IDLE;
            end
            ST_DATA: if (zero) begin
                if (is_wr && TWR > 0) begin nxt = ST_WAIT_WR; ld = 1'b1; ld_val = 4'(TWR - 1); end
                else nxt = ST_IDLE;
            end
            ST_WAIT_WR: if (zero) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    jtframe_sdram_bank_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ld),
        .load_val (ld_val),
        .cnt      (cnt),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            row      <= 13'd0;
            row_open <= 1'b0;
            is_wr    <= 1'b0;
        end else begin
            st <= nxt;
            if (st == ST_ACT && bus.bg) begin
                row      <= addr_row;
                row_open <= 1'b1;
            end
            if ((st == ST_PRE && bus.bg) || bus.set_prech) row_open <= 1'b0;
            if (issue_rw) is_wr <= bus.wr;
        end
    end

    always_comb begin
        bus.cmd     = CMD_NOP;
        bus.sdram_a = 13'd0;
        case (st)
            ST_PRE: if (bus.bg) bus.cmd = CMD_PRECHARGE;
            ST_ACT: begin
                bus.sdram_a = addr_row;
                if (bus.bg) bus.cmd = CMD_ACTIVE;
            end
            ST_RW: begin
                bus.sdram_a = {3'b000, col};
                if (issue_rw) bus.cmd = bus.wr ? CMD_WRITE : CMD_READ;
            end
            default: ;
        endcase
    end

    // read data window is the last BURST cycles of DATA, tracked by the remaining count
    assign bus.ack      = issue_rw;
    assign bus.dst      = (issue_rw && bus.wr) || (in_data && !is_wr && cnt == 4'(BURST - 1));
    assign bus.dok      = (issue_rw && bus.wr) || (in_data && (is_wr || cnt <= 4'(BURST - 1)));
    assign bus.rdy      = (BURST == 1 && issue_rw && bus.wr) || (in_data && zero);
    assign bus.dq_busy  = issue_rw || in_data;
    assign bus.br       = (st == ST_PRE) || (st == ST_ACT) || (st == ST_RW && !bus.all_dq_busy);
    assign bus.row_open = row_open;
    assign bus.row      = row;
endmodule

// File: tb/tb_jtframe_sdram_bank_ctl.sv
// Directed bench for jtframe_sdram_bank_ctl with CL=2, BURST=4, TRP=TRCD=TWR=2, CLOSE_CNT=8.
// Cycle-by-cycle expected vectors {cmd,br,ack,dst,dok,rdy,dq_busy} are hand-derived.
module tb_jtframe_sdram_bank_ctl;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   dok_cnt  = 0;

    jtframe_sdram_bank_ctl_if #(.AW(22)) bus ();

    jtframe_sdram_bank_ctl #(
        .AW(22), .CL(2), .BURST(4), .TRP(2), .TRCD(2), .TWR(2), .CLOSE_CNT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] mk_addr(input logic [12:0] r, input logic [8:0] c);
        return {r, c};
    endfunction

    // flags = {br, ack, dst, dok, rdy, dq_busy}
    function automatic logic [9:0] v(input logic [3:0] c, input logic [5:0] flags);
        return {c, flags};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.cmd, bus.br, bus.ack, bus.dst, bus.dok, bus.rdy, bus.dq_busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [9:0] exp);
        #1;
        chk(tag, 32'(obs()), 32'(exp));
        if (bus.dok) dok_cnt++;
        @(posedge clk);
        #1;
    endtask

    // DATA phase of a read, CL=2 BURST=4: one busy-only cycle, then four data words
    task automatic rd_burst(input string tag);
        step({tag, "_d0"}, v(C_NOP, 6'b000001));
        step({tag, "_d1"}, v(C_NOP, 6'b001101));
        step({tag, "_d2"}, v(C_NOP, 6'b000101));
        step({tag, "_d3"}, v(C_NOP, 6'b000101));
        step({tag, "_d4"}, v(C_NOP, 6'b000111));
    endtask

    initial begin
        rst = 1'b1;
        bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0;
        bus.bg = 1'b1; bus.all_dq_busy = 1'b0; bus.set_prech = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vec",  32'(obs()), 32'(v(C_NOP, 6'b000000)));
        chk("rst_a",    32'(bus.sdram_a), 32'd0);
        chk("rst_row",  32'(bus.row), 32'd0);
        chk("rst_open", 32'(bus.row_open), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // closed-row read of row 5
        bus.addr = mk_addr(13'h005, 9'h012); bus.rd = 1'b1;
        step("t1_idle", v(C_NOP, 6'b000000));
        #1 chk("t1_act_a", 32'(bus.sdram_a), 32'h005);
        step("t1_act", v(C_ACT, 6'b100000));
        step("t1_rcd", v(C_NOP, 6'b000000));
        #1 chk("t1_rd_a", 32'(bus.sdram_a), 32'h012);
        step("t1_read", v(C_RD, 6'b110001));
        rd_burst("t1");
        bus.rd = 1'b0;
        chk("t1_open", 32'(bus.row_open), 32'd1);
        chk("t1_row",  32'(bus.row), 32'h005);
        step("t1_after", v(C_NOP, 6'b000000));

        // row hit
        bus.addr = mk_addr(13'h005, 9'h1ff); bus.rd = 1'b1;
        step("t2_idle", v(C_NOP, 6'b000000));
        #1 chk("t2_rd_a", 32'(bus.sdram_a), 32'h1ff);
        step("t2_read", v(C_RD, 6'b110001));
        rd_burst("t2");
        bus.rd = 1'b0;

        // row miss: precharge row 5, open row 9
        bus.addr = mk_addr(13'h009, 9'h003); bus.rd = 1'b1;
        step("t3_idle", v(C_NOP, 6'b000000));
        #1 chk("t3_pre_a10", 32'(bus.sdram_a[10]), 32'd0);
        step("t3_pre", v(C_PRE, 6'b100000));
        step("t3_rp", v(C_NOP, 6'b000000));
        #1 chk("t3_act_a", 32'(bus.sdram_a), 32'h009);
        step("t3_act", v(C_ACT, 6'b100000));
        step("t3_rcd", v(C_NOP, 6'b000000));
        step("t3_read", v(C_RD, 6'b110001));
        rd_burst("t3");
        bus.rd = 1'b0;
        chk("t3_row", 32'(bus.row), 32'h009);

        // write hit, then a read queued during write recovery
        bus.addr = mk_addr(13'h009, 9'h005); bus.wr = 1'b1;
        step("t4_idle", v(C_NOP, 6'b000000));
        step("t4_write", v(C_WR, 6'b111101));
        step("t4_w1", v(C_NOP, 6'b000101));
        step("t4_w2", v(C_NOP, 6'b000101));
        step("t4_w3", v(C_NOP, 6'b000111));
        bus.wr = 1'b0;
        bus.addr = mk_addr(13'h009, 9'h007); bus.rd = 1'b1;
        step("t4_wr0", v(C_NOP, 6'b000000));
        step("t4_wr1", v(C_NOP, 6'b000000));
        step("t4_idle2", v(C_NOP, 6'b000000));
        step("t4_read", v(C_RD, 6'b110001));
        rd_burst("t4");
        bus.rd = 1'b0;

        // grant and DQ contention in RW
        dok_cnt = 0;
        bus.addr = mk_addr(13'h009, 9'h008); bus.rd = 1'b1; bus.bg = 1'b0;
        step("t5_idle", v(C_NOP, 6'b000000));
        step("t5_nog0", v(C_NOP, 6'b100000));
        bus.all_dq_busy = 1'b1;
        step("t5_nog1", v(C_NOP, 6'b000000));
        bus.all_dq_busy = 1'b0;
        step("t5_nog2", v(C_NOP, 6'b100000));
        bus.bg = 1'b1; bus.all_dq_busy = 1'b1;
        step("t5_busy", v(C_NOP, 6'b000000));
        bus.all_dq_busy = 1'b0;
        step("t5_read", v(C_RD, 6'b110001));
        rd_burst("t5");
        bus.rd = 1'b0;
        chk("t5_dok_cnt", 32'(dok_cnt), 32'd4);

        // external precharge mid-burst, then same-row access must reopen the row
        bus.addr = mk_addr(13'h009, 9'h009); bus.rd = 1'b1;
        step("t6_idle", v(C_NOP, 6'b000000));
        step("t6_read", v(C_RD, 6'b110001));
        step("t6_d0", v(C_NOP, 6'b000001));
        bus.set_prech = 1'b1;
        step("t6_d1", v(C_NOP, 6'b001101));
        bus.set_prech = 1'b0;
        step("t6_d2", v(C_NOP, 6'b000101));
        step("t6_d3", v(C_NOP, 6'b000101));
        step("t6_d4", v(C_NOP, 6'b000111));
        bus.rd = 1'b0;
        chk("t6_closed", 32'(bus.row_open), 32'd0);
        bus.rd = 1'b1; bus.bg = 1'b0;
        step("t6_idle2", v(C_NOP, 6'b000000));
        step("t6_act_stall", v(C_NOP, 6'b100000));
        bus.bg = 1'b1;
        step("t6_act", v(C_ACT, 6'b100000));
        step("t6_rcd", v(C_NOP, 6'b000000));
        step("t6_read2", v(C_RD, 6'b110001));
        rd_burst("t6b");
        bus.rd = 1'b0;

`ifdef JTFRAME_SDRAM_ROWCLOSE_EN
        for (int i = 0; i < 7; i++) step("t7_idle", v(C_NOP, 6'b000000));
        step("t7_autopre", v(C_PRE, 6'b100000));
        chk("t7_closed", 32'(bus.row_open), 32'd0);
        step("t7_rp", v(C_NOP, 6'b000000));
        step("t7_back", v(C_NOP, 6'b000000));
`else
        for (int i = 0; i < 12; i++) step("t7_idle", v(C_NOP, 6'b000000));
        chk("t7_still_open", 32'(bus.row_open), 32'd1);
`endif

        // asynchronous reset in the middle of a read burst
        bus.addr = mk_addr(13'h009, 9'h001); bus.rd = 1'b1;
        for (int i = 0; i < 20 && !bus.dok; i++) begin
            @(posedge clk); #1;
        end
        chk("t8_dok_seen", 32'(bus.dok), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t8_rst_vec",  32'(obs()), 32'(v(C_NOP, 6'b000000)));
        chk("t8_rst_open", 32'(bus.row_open), 32'd0);
        chk("t8_rst_a",    32'(bus.sdram_a), 32'd0);
        bus.rd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        step("t8_idle", v(C_NOP, 6'b000000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
